// File: rtl/axi_lite_req_aligner.sv
// AXI-Lite request aligner: one-entry AW/W/AR buffers, joint AW+W reissue, one txn in flight.
// Define AXI_LITE_ALIGNER_RR_EN for round-robin read/write arbitration (default: write priority).

package axi_lite_req_aligner_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [2:0]       prot;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [2:0]       prot;
  } ar_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [1:0]       resp;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_lite_rsp_t;

endpackage

module axi_lite_req_aligner #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter type axi_lite_req_t =
    axi_lite_req_aligner_pkg::axi_lite_req_t,
  parameter type axi_lite_rsp_t =
    axi_lite_req_aligner_pkg::axi_lite_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t slv_req_i,
  output axi_lite_rsp_t slv_rsp_o,
  output axi_lite_req_t mst_req_o,
  input  axi_lite_rsp_t mst_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_WR_RESP,
    S_RD_RESP
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic r_aw_full;
  logic r_w_full;
  logic r_ar_full;
  logic r_aw_sent;
  logic r_w_sent;

  logic [AddrWidth-1:0] r_aw_addr;
  logic [2:0]           r_aw_prot;
  logic [DataWidth-1:0] r_w_data;
  logic [StrbWidth-1:0] r_w_strb;
  logic [AddrWidth-1:0] r_ar_addr;
  logic [2:0]           r_ar_prot;

  logic w_idle;
  logic w_in_wr;
  logic w_in_rd;
  logic w_aw_load;
  logic w_w_load;
  logic w_ar_load;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_wr_done;
  logic w_wr_rdy;
  logic w_rd_rdy;
  logic w_grant_wr;
  logic w_grant_rd;

  assign w_idle  = (r_state == S_IDLE);
  assign w_in_wr = (r_state == S_WR_ISSUE);
  assign w_in_rd = (r_state == S_RD_ISSUE);

  // ready is ~full, so a load can never meet a free on the same buffer
  assign w_aw_load = slv_req_i.aw_valid & ~r_aw_full;
  assign w_w_load  = slv_req_i.w_valid & ~r_w_full;
  assign w_ar_load = slv_req_i.ar_valid & ~r_ar_full;

  assign w_aw_hs = w_in_wr & ~r_aw_sent
                 & mst_rsp_i.aw_ready;
  assign w_w_hs  = w_in_wr & ~r_w_sent
                 & mst_rsp_i.w_ready;
  assign w_ar_hs = w_in_rd & mst_rsp_i.ar_ready;

  assign w_wr_done = w_in_wr
                   & (r_aw_sent | w_aw_hs)
                   & (r_w_sent | w_w_hs);

  assign w_b_hs = (r_state == S_WR_RESP)
                & mst_rsp_i.b_valid
                & slv_req_i.b_ready;
  assign w_r_hs = (r_state == S_RD_RESP)
                & mst_rsp_i.r_valid
                & slv_req_i.r_ready;

  // look ahead at this cycle's loads so issue follows capture by one cycle
  assign w_wr_rdy = (r_aw_full | w_aw_load)
                  & (r_w_full | w_w_load);
  assign w_rd_rdy = r_ar_full | w_ar_load;

`ifdef AXI_LITE_ALIGNER_RR_EN
  logic r_last_grant;

  assign w_grant_wr = w_idle & w_wr_rdy
                    & (~w_rd_rdy | r_last_grant);

  // 1 = read granted last
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_grant <= 1'b1;
    end else if (w_grant_wr | w_grant_rd) begin
      r_last_grant <= w_grant_rd;
    end
  end
`else
  assign w_grant_wr = w_idle & w_wr_rdy;
`endif

  assign w_grant_rd = w_idle & w_rd_rdy & ~w_grant_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_aw_prot <= '0;
    end else if (w_aw_load) begin
      r_aw_full <= 1'b1;
      r_aw_addr <= slv_req_i.aw.addr;
      r_aw_prot <= slv_req_i.aw.prot;
    end else if (w_wr_done) begin
      r_aw_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w_full <= 1'b0;
      r_w_data <= '0;
      r_w_strb <= '0;
    end else if (w_w_load) begin
      r_w_full <= 1'b1;
      r_w_data <= slv_req_i.w.data;
      r_w_strb <= slv_req_i.w.strb;
    end else if (w_wr_done) begin
      r_w_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ar_full <= 1'b0;
      r_ar_addr <= '0;
      r_ar_prot <= '0;
    end else if (w_ar_load) begin
      r_ar_full <= 1'b1;
      r_ar_addr <= slv_req_i.ar.addr;
      r_ar_prot <= slv_req_i.ar.prot;
    end else if (w_ar_hs) begin
      r_ar_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_sent <= 1'b0;
      r_w_sent  <= 1'b0;
    end else if (w_wr_done) begin
      r_aw_sent <= 1'b0;
      r_w_sent  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_sent <= 1'b1;
      if (w_w_hs)  r_w_sent  <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt = S_WR_ISSUE;
        end else if (w_grant_rd) begin
          w_state_nxt = S_RD_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (w_wr_done) w_state_nxt = S_WR_RESP;
      end
      S_RD_ISSUE: begin
        if (w_ar_hs) w_state_nxt = S_RD_RESP;
      end
      S_WR_RESP: begin
        if (w_b_hs) w_state_nxt = S_IDLE;
      end
      S_RD_RESP: begin
        if (w_r_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    slv_rsp_o = '0;
    mst_req_o = '0;

    slv_rsp_o.aw_ready = ~r_aw_full;
    slv_rsp_o.w_ready  = ~r_w_full;
    slv_rsp_o.ar_ready = ~r_ar_full;

    mst_req_o.aw.addr = r_aw_addr;
    mst_req_o.aw.prot = r_aw_prot;
    mst_req_o.w.data  = r_w_data;
    mst_req_o.w.strb  = r_w_strb;
    mst_req_o.ar.addr = r_ar_addr;
    mst_req_o.ar.prot = r_ar_prot;

    unique case (r_state)
      S_WR_ISSUE: begin
        mst_req_o.aw_valid = ~r_aw_sent;
        mst_req_o.w_valid  = ~r_w_sent;
      end
      S_RD_ISSUE: begin
        mst_req_o.ar_valid = 1'b1;
      end
      S_WR_RESP: begin
        slv_rsp_o.b       = mst_rsp_i.b;
        slv_rsp_o.b_valid = mst_rsp_i.b_valid;
        mst_req_o.b_ready = slv_req_i.b_ready;
      end
      S_RD_RESP: begin
        slv_rsp_o.r       = mst_rsp_i.r;
        slv_rsp_o.r_valid = mst_rsp_i.r_valid;
        mst_req_o.r_ready = slv_req_i.r_ready;
      end
      default: ;
    endcase
  end

endmodule
